// File: rtl/snn_pkg.sv
// Shared defaults and state encoding for the spiking-network output stage.
package snn_pkg;

    localparam int unsigned NUM_NEURONS_DEF = 8;
    localparam int unsigned WINDOW_DEF      = 20;
    localparam int unsigned CNT_W_DEF       = 5;
    localparam int unsigned IDX_W_DEF       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } dec_state_e;

endpackage

// File: rtl/spike_sat_counter.sv
// One per-neuron spike counter that sticks at its maximum instead of wrapping.
module spike_sat_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             spike_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i && spike_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per neuron over a window, then scans for the
// most active neuron and offers the result on a valid/ready handshake.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int unsigned WINDOW      = WINDOW_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   spike_valid,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [IDX_W-1:0]       class_idx,
    output logic [CNT_W-1:0]       class_count,
    output logic                   tie
);

    localparam int unsigned TS_W = $clog2(WINDOW + 1);

    dec_state_e       state_q;
    logic [TS_W-1:0]  ts_q;
    logic [IDX_W-1:0] scan_q;
    logic             busy_q;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] best_q;
    logic             tie_q;

    logic [CNT_W-1:0] cnt [NUM_NEURONS];
    logic             clr_c;
    logic             acc_en_c;
    logic [CNT_W-1:0] scan_cnt_c;
    logic             last_ts_c;
    logic             last_k_c;

    assign clr_c      = (state_q == IDLE) && start;
    assign acc_en_c   = (state_q == ACCUM) && spike_valid;
    assign scan_cnt_c = cnt[scan_q];
    assign last_ts_c  = (ts_q == TS_W'(WINDOW - 1));
    assign last_k_c   = (scan_q == IDX_W'(NUM_NEURONS - 1));

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr_c),
            .en_i    (acc_en_c),
            .spike_i (spike_in[g]),
            .count_o (cnt[g])
        );
    end

    // Control FSM, timestep counter and one-neuron-per-cycle argmax scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            scan_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            best_q  <= '0;
            tie_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        ts_q    <= '0;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        best_q  <= '0;
                        tie_q   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (spike_valid) begin
                        ts_q <= ts_q + TS_W'(1);
                        if (last_ts_c) begin
                            state_q <= ARGMAX;
                            scan_q  <= '0;
                        end
                    end
                end
                ARGMAX: begin
                    // Strict > keeps the lowest index on equal counts.
                    if (scan_q == '0) begin
                        best_q <= scan_cnt_c;
                        idx_q  <= '0;
                        tie_q  <= 1'b0;
                    end else if (scan_cnt_c > best_q) begin
                        best_q <= scan_cnt_c;
                        idx_q  <= scan_q;
                        tie_q  <= 1'b0;
                    end else if (scan_cnt_c == best_q) begin
                        tie_q  <= 1'b1;
                    end
                    scan_q <= scan_q + IDX_W'(1);
                    if (last_k_c) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign class_idx    = idx_q;
    assign class_count  = best_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: vector table of windows plus
// hand-written handshake, abort and saturation sequences.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset, start, start40, spike_valid, result_ready;
    logic [7:0] spike_in;

    logic       busy, rv, tie;
    logic [2:0] idx;
    logic [4:0] cnt;
    logic       busy40, rv40, tie40;
    logic [2:0] idx40;
    logic [4:0] cnt40;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_NEURONS(8), .WINDOW(20), .CNT_W(5), .IDX_W(3)) dut (
        .clk (clk), .reset (reset), .start (start), .spike_valid (spike_valid),
        .spike_in (spike_in), .busy (busy), .result_valid (rv),
        .result_ready (result_ready), .class_idx (idx), .class_count (cnt), .tie (tie)
    );

    spike_rate_decoder #(.NUM_NEURONS(8), .WINDOW(40), .CNT_W(5), .IDX_W(3)) dut40 (
        .clk (clk), .reset (reset), .start (start40), .spike_valid (spike_valid),
        .spike_in (spike_in), .busy (busy40), .result_valid (rv40),
        .result_ready (result_ready), .class_idx (idx40), .class_count (cnt40), .tie (tie40)
    );

    typedef struct {
        string      name;
        logic [7:0] pa;
        int         na;
        logic [7:0] pb;
        int         nb;
        logic [2:0] ei;
        logic [4:0] ec;
        logic       et;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Starts a window, feeds na cycles of pa then nb cycles of pb, checks result.
    task automatic run_window(input bit w40, input string nm,
                              input logic [7:0] pa, input int na,
                              input logic [7:0] pb, input int nb,
                              input logic [2:0] ei, input logic [4:0] ec, input logic et);
        int e;
        if (w40) start40 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start40 = 1'b0;
        chk({nm, " busy_after_start"}, int'(w40 ? busy40 : busy), 1);
        chk({nm, " count_cleared"}, int'(w40 ? cnt40 : cnt), 0);
        for (int i = 0; i < na + nb; i++) begin
            spike_valid = 1'b1;
            spike_in    = (i < na) ? pa : pb;
            @(negedge clk);
        end
        spike_valid = 1'b0;
        spike_in    = 8'h00;
        e = na + nb;
        while (!(w40 ? rv40 : rv) && e < 200) begin
            @(negedge clk);
            e++;
        end
        chk({nm, " latency"}, e, na + nb + 8);
        chk({nm, " class_idx"}, int'(w40 ? idx40 : idx), int'(ei));
        chk({nm, " class_count"}, int'(w40 ? cnt40 : cnt), int'(ec));
        chk({nm, " tie"}, int'(w40 ? tie40 : tie), int'(et));
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({nm, " valid_drop"}, int'(w40 ? rv40 : rv), 0);
        chk({nm, " busy_drop"}, int'(w40 ? busy40 : busy), 0);
    endtask

    initial begin
        int e;
        vecs[0] = '{"solo_bit3",   8'h08, 20, 8'h00, 0,  3'd3, 5'd20, 1'b0};
        vecs[1] = '{"tie_b1_b5",   8'h02, 10, 8'h20, 10, 3'd1, 5'd10, 1'b1};
        vecs[2] = '{"all_zero",    8'h00, 20, 8'h00, 0,  3'd0, 5'd0,  1'b1};
        vecs[3] = '{"all_ones",    8'hFF, 20, 8'h00, 0,  3'd0, 5'd20, 1'b1};
        vecs[4] = '{"b7_beats_b0", 8'h81, 5,  8'h80, 15, 3'd7, 5'd20, 1'b0};
        vecs[5] = '{"b3_beats_b2", 8'h0C, 12, 8'h08, 8,  3'd3, 5'd20, 1'b0};
        vecs[6] = '{"b6_beats_b5", 8'h60, 15, 8'h40, 5,  3'd6, 5'd20, 1'b0};
        vecs[7] = '{"tie_b0_b4",   8'h11, 20, 8'h00, 0,  3'd0, 5'd20, 1'b1};

        reset = 1'b1; start = 1'b0; start40 = 1'b0;
        spike_valid = 1'b0; spike_in = 8'h00; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset result_valid", int'(rv), 0);
        chk("reset class_idx", int'(idx), 0);
        chk("reset class_count", int'(cnt), 0);
        chk("reset tie", int'(tie), 0);

        // Ready and spikes while idle have no effect.
        result_ready = 1'b1; spike_valid = 1'b1; spike_in = 8'hFF;
        @(negedge clk);
        result_ready = 1'b0; spike_valid = 1'b0; spike_in = 8'h00;
        chk("idle_ready result_valid", int'(rv), 0);
        chk("idle_ready busy", int'(busy), 0);

        for (int v = 0; v < 8; v++)
            run_window(1'b0, vecs[v].name, vecs[v].pa, vecs[v].na,
                       vecs[v].pb, vecs[v].nb, vecs[v].ei, vecs[v].ec, vecs[v].et);

        // Alternating valid; invalid cycles carry 8'hFF which must not count.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            spike_valid = (i % 2 == 0);
            spike_in    = (i % 2 == 0) ? 8'h04 : 8'hFF;
            @(negedge clk);
        end
        spike_valid = 1'b0; spike_in = 8'h00;
        e = 40;
        while (!rv && e < 200) begin
            @(negedge clk);
            e++;
        end
        chk("gapped latency", e, 39 + 8);
        for (int j = 0; j < 5; j++) begin
            start = (j % 2 == 0);
            @(negedge clk);
            chk("hold result_valid", int'(rv), 1);
            chk("hold class_idx", int'(idx), 2);
            chk("hold class_count", int'(cnt), 20);
            chk("hold tie", int'(tie), 0);
        end
        start = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; result_ready = 1'b0;
        chk("done_start result_valid", int'(rv), 0);
        chk("done_start busy", int'(busy), 0);
        @(negedge clk);
        chk("done_start not_accepted", int'(busy), 0);
        chk("idle_hold class_count", int'(cnt), 20);
        chk("idle_hold class_idx", int'(idx), 2);

        // Abort a window with reset, then run a clean one.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spike_valid = 1'b1; spike_in = 8'hFF;
            @(negedge clk);
        end
        spike_valid = 1'b0; spike_in = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort result_valid", int'(rv), 0);
        chk("abort class_count", int'(cnt), 0);
        repeat (3) @(negedge clk);
        chk("abort no_result", int'(rv), 0);
        run_window(1'b0, "after_abort", 8'h40, 20, 8'h00, 0, 3'd6, 5'd20, 1'b0);

        // Longer window: both bit0 and bit7 saturate at 31.
        run_window(1'b1, "sat_tie", 8'h81, 35, 8'h80, 5, 3'd0, 5'd31, 1'b1);
        // bit0 stops at 30, bit7 saturates at 31.
        run_window(1'b1, "sat_b7", 8'h81, 30, 8'h80, 10, 3'd7, 5'd31, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
